// File: rtl/case_6_mul_arb_pkg.sv
// Shared constants, state encoding and width helper for the shared-multiplier arbiter.
package case_6_mul_arb_pkg;

    localparam int DIN_W       = 11;
    localparam int DOUT_W      = 15;
    localparam int NUM_REQ_DEF = 4;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/case_6_mul_11s_11s_15_1_1.sv
// Combinational signed multiplier; result is the low dout_WIDTH bits of the full product.
module case_6_mul_11s_11s_15_1_1 #(
    parameter int din0_WIDTH = 11,
    parameter int din1_WIDTH = 11,
    parameter int dout_WIDTH = 15
) (
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic signed [dout_WIDTH-1:0] dout
);

    localparam int PW = din0_WIDTH + din1_WIDTH;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;

    assign a_ext = PW'(din0);
    assign b_ext = PW'(din1);
    // Truncation gives the modular wrap; overflow is intentionally silent.
    assign dout  = dout_WIDTH'(a_ext * b_ext);

endmodule

// File: rtl/case_6_mul_arbiter.sv
// Round-robin sharing of one signed multiplier between NUM_REQ requesters,
// with a one-entry tagged result buffer drained over a valid/ready port.
module case_6_mul_arbiter
    import case_6_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DIN_W-1:0]  req_a,
    input  logic [NUM_REQ*DIN_W-1:0]  req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DOUT_W-1:0]         rsp_data,
    output logic [15:0]               grant_cnt
);

    function automatic int wrap_add(input int base, input int k);
        int s;
        s = base + k;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    state_e                    state_q, state_d;
    logic signed [DOUT_W-1:0]  data_q, data_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [ID_W-1:0]           rr_q, rr_d;
    logic [15:0]               cnt_q, cnt_d;

    logic                      slot_free;
    logic                      grant_vld;
    logic [ID_W-1:0]           gnt_idx;
    logic signed [DIN_W-1:0]   a_sel;
    logic signed [DIN_W-1:0]   b_sel;
    logic signed [DOUT_W-1:0]  prod;

    assign rsp_valid = (state_q == FULL);
    assign slot_free = !rsp_valid || rsp_ready;

    // Descending scan so the lane closest to rr_q wins; depends only on valids, never on operands.
    always_comb begin
        grant_vld = 1'b0;
        gnt_idx   = '0;
        if (slot_free && !ap_rst) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[wrap_add(int'(rr_q), k)]) begin
                    grant_vld = 1'b1;
                    gnt_idx   = ID_W'(wrap_add(int'(rr_q), k));
                end
            end
        end
        req_ready = grant_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    assign a_sel = req_a[int'(gnt_idx)*DIN_W +: DIN_W];
    assign b_sel = req_b[int'(gnt_idx)*DIN_W +: DIN_W];

    case_6_mul_11s_11s_15_1_1 #(
        .din0_WIDTH (DIN_W),
        .din1_WIDTH (DIN_W),
        .dout_WIDTH (DOUT_W)
    ) u_mul (
        .din0 (a_sel),
        .din1 (b_sel),
        .dout (prod)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY:   if (grant_vld) state_d = FULL;
            FULL:    if (rsp_ready && !grant_vld) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        // A grant in the drain cycle overwrites the outgoing result, so there is no bubble.
        if (grant_vld) begin
            data_d = prod;
            id_d   = gnt_idx;
            rr_d   = ID_W'(wrap_add(int'(gnt_idx), 1));
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_case_6_mul_arbiter.sv
// Scoreboard bench for case_6_mul_arbiter: directed requests push expected results, a monitor checks them on drain.
module tb_case_6_mul_arbiter;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [43:0] req_a;
    logic [43:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [14:0] rsp_data;
    logic [15:0] grant_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [14:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Lane i: a = 100*(i+1), b = -7  ->  -700, -1400, -2100, -2800 wrapped to 15 bits.
    localparam logic [14:0] EXP_RR [4] = '{15'h7D44, 15'h7A88, 15'h77CC, 15'h7510};

    always #5 ap_clk = ~ap_clk;

    case_6_mul_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .grant_cnt (grant_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_lane(input int i, input int a, input int b);
        req_a[i*11 +: 11] = a[10:0];
        req_b[i*11 +: 11] = b[10:0];
    endtask

    task automatic push(input int id, input int data);
        exp_t e;
        e.id   = 2'(id);
        e.data = 15'(data);
        sb.push_back(e);
    endtask

    task automatic nxt();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic neg();
        @(negedge ap_clk);
    endtask

    always @(negedge ap_clk) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d data=%0h expected no response", rsp_id, rsp_data);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ap_rst    = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        nxt();
        nxt();
        neg();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_data", 32'(rsp_data), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_cnt", 32'(grant_cnt), 32'h0);
        nxt();
        ap_rst    = 1'b0;
        req_valid = 4'h0;
        neg();
        chk("idle_ready", 32'(req_ready), 32'h0);

        // Single request on lane 2
        nxt();
        set_lane(2, -3, 5);
        req_valid = 4'b0100;
        neg();
        chk("single_ready", 32'(req_ready), 32'b0100);
        push(2, 'h7FF1);
        nxt();
        req_valid = 4'h0;
        chk("single_lat_valid", 32'(rsp_valid), 32'h1);
        neg();
        chk("single_ready_drop", 32'(req_ready), 32'h0);

        // Overflow wrap on lane 3 (pointer is at 3, then 0)
        nxt();
        set_lane(3, 1023, 1023);
        req_valid = 4'b1000;
        neg();
        chk("ovf1_ready", 32'(req_ready), 32'b1000);
        push(3, 'h7801);
        nxt();
        set_lane(3, -1024, -1024);
        neg();
        chk("ovf2_ready", 32'(req_ready), 32'b1000);
        push(3, 'h0000);
        nxt();
        req_valid = 4'h0;
        chk("cnt_after_ovf", 32'(grant_cnt), 32'd3);

        // All lanes valid, continuous drain
        for (int i = 0; i < 4; i++) set_lane(i, 100 * (i + 1), -7);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            neg();
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            push(k % 4, int'(EXP_RR[k % 4]));
            nxt();
        end
        req_valid = 4'h0;
        chk("rr_cnt", 32'(grant_cnt), 32'd11);
        neg();
        nxt();

        // Backpressure
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        neg();
        chk("bp_ready", 32'(req_ready), 32'b0001);
        push(0, int'(EXP_RR[0]));
        for (int k = 0; k < 5; k++) begin
            nxt();
            neg();
            chk("bp_stall_ready", 32'(req_ready), 32'h0);
            chk("bp_stall_valid", 32'(rsp_valid), 32'h1);
            chk("bp_stall_data", 32'(rsp_data), 32'(EXP_RR[0]));
            chk("bp_stall_id", 32'(rsp_id), 32'h0);
        end
        nxt();
        rsp_ready = 1'b1;
        neg();
        chk("bp_drain_ready", 32'(req_ready), 32'b0010);
        push(1, int'(EXP_RR[1]));
        nxt();
        chk("nobubble_valid", 32'(rsp_valid), 32'h1);
        chk("nobubble_id", 32'(rsp_id), 32'h1);
        neg();
        chk("rr2_ready", 32'(req_ready), 32'b0100);
        push(2, int'(EXP_RR[2]));
        nxt();

        // Reset with a result buffered and pointer at 3
        ap_rst = 1'b1;
        neg();
        chk("rst_mid_ready", 32'(req_ready), 32'h0);
        nxt();
        ap_rst = 1'b0;
        chk("rstm_valid", 32'(rsp_valid), 32'h0);
        chk("rstm_cnt", 32'(grant_cnt), 32'h0);
        chk("rstm_data", 32'(rsp_data), 32'h0);
        neg();
        chk("rst_after_ready", 32'(req_ready), 32'b0001);
        push(0, int'(EXP_RR[0]));
        nxt();
        req_valid = 4'h0;
        neg();
        nxt();

        // Counter saturation: one grant already counted
        set_lane(0, 0, 0);
        req_valid = 4'b0001;
        for (int i = 0; i < 65533; i++) begin
            neg();
            push(0, 0);
            nxt();
        end
        chk("sat_pre", 32'(grant_cnt), 32'hFFFE);
        neg();
        push(0, 0);
        nxt();
        chk("sat_hit", 32'(grant_cnt), 32'hFFFF);
        for (int i = 0; i < 3; i++) begin
            neg();
            push(0, 0);
            nxt();
        end
        chk("sat_hold", 32'(grant_cnt), 32'hFFFF);
        req_valid = 4'h0;
        neg();
        nxt();
        neg();
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
